// File: rtl/parity_frame_checker.sv
// rtl/parity_frame_checker.sv - serial even-parity frame receiver with status flags and counters
module parity_frame_checker #(
    parameter int DATA_BITS = 4,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_en,
    input  logic                 line,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic [CNT_W-1:0]     err_cnt
);

    localparam int IDX_W = (DATA_BITS < 2) ? 1 : $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        RESYNC = 3'd4
    } state_t;

    state_t                 state, state_n;
    logic [DATA_BITS-1:0]   shreg, shreg_n;
    logic [IDX_W-1:0]       idx, idx_n;
    logic                   rxor, rxor_n;
    logic                   perr_q, perr_q_n;

    logic [DATA_BITS-1:0]   data_out_n;
    logic                   done_n;
    logic                   parity_err_n;
    logic                   frame_err_n;
    logic                   busy_n;
    logic [CNT_W-1:0]       frame_cnt_n;
    logic [CNT_W-1:0]       err_cnt_n;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            shreg      <= '0;
            idx        <= '0;
            rxor       <= 1'b0;
            perr_q     <= 1'b0;
            data_out   <= '0;
            done       <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
            frame_cnt  <= '0;
            err_cnt    <= '0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            idx        <= idx_n;
            rxor       <= rxor_n;
            perr_q     <= perr_q_n;
            data_out   <= data_out_n;
            done       <= done_n;
            parity_err <= parity_err_n;
            frame_err  <= frame_err_n;
            busy       <= busy_n;
            frame_cnt  <= frame_cnt_n;
            err_cnt    <= err_cnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        shreg_n      = shreg;
        idx_n        = idx;
        rxor_n       = rxor;
        perr_q_n     = perr_q;
        data_out_n   = data_out;
        done_n       = 1'b0;
        parity_err_n = parity_err;
        frame_err_n  = frame_err;
        frame_cnt_n  = frame_cnt;
        err_cnt_n    = err_cnt;

        if (bit_en) begin
            case (state)
                IDLE: begin
                    if (!line) begin
                        state_n = DATA;
                        idx_n   = '0;
                        rxor_n  = 1'b0;
                        shreg_n = '0;
                    end
                end
                DATA: begin
                    // MSB arrives first, so each new bit pushes earlier ones up.
                    shreg_n = (shreg << 1) | DATA_BITS'(line);
                    rxor_n  = rxor ^ line;
                    if (idx == LAST_IDX) begin
                        state_n = PARITY;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
                PARITY: begin
                    perr_q_n = line ^ rxor;
                    state_n  = STOP;
                end
                STOP: begin
                    done_n       = 1'b1;
                    data_out_n   = shreg;
                    parity_err_n = perr_q;
                    frame_err_n  = !line;
                    frame_cnt_n  = frame_cnt + CNT_W'(1);
                    // One increment per bad frame, even if both flags are set.
                    if ((perr_q || !line) && (err_cnt != CNT_MAX)) begin
                        err_cnt_n = err_cnt + CNT_W'(1);
                    end
                    state_n = line ? IDLE : RESYNC;
                end
                RESYNC: begin
                    if (line) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        busy_n = (state_n != IDLE);
    end

endmodule
